// File: rtl/spm_pkg.sv
// Shared constants and helpers for the shift-add serial-parallel multiplier.
package spm_pkg;

  localparam int SPM_WIDTH_DEFAULT = 32;
  localparam int PROD_W = 2 * SPM_WIDTH_DEFAULT;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 states.
  function automatic int spm_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spm_addstep.sv
// One shift-add step: conditionally add the multiplicand to the upper accumulator half.
module spm_addstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_p_hi,
  input  logic [WIDTH-1:0] i_mc,
  input  logic             i_bit,
  output logic [WIDTH:0]   o_sum
);

  assign o_sum = {1'b0, i_p_hi} + {1'b0, (i_bit ? i_mc : '0)};

endmodule

// File: rtl/spm_datapath.sv
// Serial-parallel multiplier datapath: one multiplier bit per shift strobe.
// Optional two's-complement operands via the SPM_SIGNED_EN macro.
module spm_datapath
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld,
  input  logic               shift,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  output logic [2*WIDTH-1:0] prod,
  output logic               proddone
);

  localparam int CW = spm_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0]   r_mc;
  logic [WIDTH-1:0]   r_mp;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_mc_ld;
  logic [WIDTH-1:0]   w_mp_ld;
  logic               w_step;

`ifdef SPM_SIGNED_EN
  logic r_neg;

  // Magnitude of the most negative value is 2^(W-1), exact as an unsigned W-bit value.
  assign w_mc_ld = mc[WIDTH-1] ? (WIDTH'(0) - mc) : mc;
  assign w_mp_ld = mp[WIDTH-1] ? (WIDTH'(0) - mp) : mp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (ld) begin
      r_neg <= mc[WIDTH-1] ^ mp[WIDTH-1];
    end
  end

  assign prod = r_neg ? ((2*WIDTH)'(0) - r_acc) : r_acc;
`else
  assign w_mc_ld = mc;
  assign w_mp_ld = mp;
  assign prod    = r_acc;
`endif

  assign w_step   = shift && !ld && (r_cnt < CNT_MAX);
  assign proddone = (r_cnt == CNT_MAX);

  spm_addstep #(
    .WIDTH(WIDTH)
  ) u_addstep (
    .i_p_hi(r_acc[2*WIDTH-1:WIDTH]),
    .i_mc  (r_mc),
    .i_bit (r_mp[0]),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mc  <= '0;
      r_mp  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (ld) begin
      r_mc  <= w_mc_ld;
      r_mp  <= w_mp_ld;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      r_mp  <= r_mp >> 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spm_datapath.sv
// Scoreboard bench for spm_datapath (WIDTH=8); honours SPM_SIGNED_EN like the RTL.
module tb_spm_datapath;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ld;
  logic           shift;
  logic [W-1:0]   mc;
  logic [W-1:0]   mp;
  logic [2*W-1:0] prod;
  logic           proddone;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;
  logic prev_done = 1'b0;

  spm_datapath #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld),
    .shift   (shift),
    .mc      (mc),
    .mp      (mp),
    .prod    (prod),
    .proddone(proddone)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SPM_SIGNED_EN
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa * sb);
`else
    return 16'({8'b0, a} * {8'b0, b});
`endif
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: a product is presented on each rising proddone.
  always @(negedge clk) begin
    if (proddone && !prev_done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL prod_unexpected: got %0h expected none", prod);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (prod !== e) begin
          n_err++;
          $display("FAIL prod: got %0h expected %0h", prod, e);
        end
      end
    end
    prev_done <= proddone;
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit rnd_stall, input int gap_at, input int gap_len);
    int shifts;
    int cyc;
    int g;
    shifts = 0; cyc = 0; g = 0;
    @(negedge clk);
    ld = 1'b1; mc = a; mp = b;
    last_exp = model(a, b);
    exp_q.push_back(last_exp);
    @(negedge clk);
    ld = 1'b0;
    chk("done_after_ld", {15'd0, proddone}, 16'd0);
    while (!proddone && cyc < 80) begin
      if (shifts == gap_at && g < gap_len) begin
        shift = 1'b0; g++;
      end else if (rnd_stall && ($urandom_range(0, 3) == 0)) begin
        shift = 1'b0;
      end else begin
        shift = 1'b1;
      end
      @(negedge clk);
      if (shift) shifts++;
      cyc++;
    end
    shift = 1'b0;
    chk("latency_shifts", 16'(shifts), 16'(W));
    @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; ld = 1'b0; shift = 1'b0; mc = '0; mp = '0;
    #2;
    chk("reset_prod", prod, 16'd0);
    chk("reset_done", {15'd0, proddone}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd13, 8'd11, 1'b0, -1, 0);
    run_op(8'd255, 8'd255, 1'b0, -1, 0);
    run_op(8'd0, 8'd200, 1'b0, -1, 0);

    // Extra shifts after completion must not disturb the result.
    shift = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_prod", prod, last_exp);
      chk("hold_done", {15'd0, proddone}, 16'd1);
    end
    shift = 1'b0;

    run_op(8'd77, 8'd201, 1'b0, 4, 3);
    run_op(8'hFD, 8'd7, 1'b0, -1, 0);
    run_op(8'h80, 8'h80, 1'b0, -1, 0);
    run_op(8'h80, 8'h7F, 1'b0, 2, 2);

    // Reset mid-operation after four shifts.
    @(negedge clk);
    ld = 1'b1; mc = 8'd99; mp = 8'd123;
    @(negedge clk);
    ld = 1'b0; shift = 1'b1;
    repeat (4) @(negedge clk);
    shift = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_prod", prod, 16'd0);
    chk("midrst_done", {15'd0, proddone}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd6, 8'd7, 1'b0, -1, 0);

    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'b1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
